dmem_arbiter: RTL and testbench

//  Shares one single-port data RAM between two requesters: the MEM stage (load/store) and the IF stage (instruction fetch).

---
 rtl/mips_pkg.sv | 15 +
 rtl/dmem_arbiter.sv | 117 +++++++++++
 tb/tb_dmem_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the data-memory arbiter.
// Holds the FSM state encoding and the grant identifiers.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic GRANT_MEM = 1'b0;
  localparam logic GRANT_IF  = 1'b1;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares one single-port data RAM between MEM (load/store) and IF (fetch).
// Ports: mem_*/if_* req/ready pipeline side, ram_* RAM side, stall out.
module dmem_arbiter
  import mips_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_ready,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  output logic          stall,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  state_t     state;
  logic       win;
  logic       win_we;
  logic       last_grant;
  logic [2:0] cnt;
  logic       pick;

  // Lone requester wins; on contention the one not granted last wins.
  always_comb begin
    pick = ~last_grant;
    unique case (1'b1)
      mem_req & ~if_req: pick = GRANT_MEM;
      if_req & ~mem_req: pick = GRANT_IF;
      default:           pick = ~last_grant;
    endcase
  end

  assign stall = (mem_req & ~mem_ready)
               | (if_req & ~if_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      win        <= GRANT_MEM;
      win_we     <= 1'b0;
      last_grant <= GRANT_IF;
      cnt        <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      mem_ready  <= 1'b0;
      if_ready   <= 1'b0;
      mem_rdata  <= '0;
      if_rdata   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_req | if_req) begin
            win        <= pick;
            last_grant <= pick;
            ram_en     <= 1'b1;
            if (pick == GRANT_MEM) begin
              win_we    <= mem_we;
              ram_we    <= mem_we;
              ram_addr  <= mem_addr;
              ram_wdata <= mem_wdata;
            end else begin
              win_we    <= 1'b0;
              ram_we    <= 1'b0;
              ram_addr  <= if_addr;
              ram_wdata <= '0;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          cnt    <= 3'(LAT - 1);
          state  <= WAIT;
        end
        WAIT: begin
          // cnt hits 0 in the cycle ram_rdata is valid
          if (cnt == 3'd0) begin
            if (win == GRANT_IF) begin
              if_rdata <= ram_rdata;
              if_ready <= 1'b1;
            end else begin
              if (!win_we) mem_rdata <= ram_rdata;
              mem_ready <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          mem_ready <= 1'b0;
          if_ready  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a RAM model and scoreboard.
// Expected read data is queued at request time and popped on ready.
module tb_dmem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          stall;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] ram [16];
  bit            ram_init = 1'b0;
  logic [DW-1:0] pipe [LAT];
  logic [DW-1:0] mem_q [$];
  logic [DW-1:0] if_q [$];
  logic [DW-1:0] last_load = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .stall(stall),
    .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return (i == 1) ? 32'h1234_5678 : (32'hA500_0000 | 32'(i));
  endfunction

  // RAM: read data valid LAT cycles after the ram_en cycle
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
      ram_init <= 1'b1;
    end else if (ram_en && ram_we) begin
      ram[ram_addr[5:2]] <= ram_wdata;
    end
    pipe[0] <= (ram_en && !ram_we) ? ram[ram_addr[5:2]]
                                   : 32'hBAD0_BAD0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_rdata = pipe[LAT-1];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (rst_n) begin
      if (mem_ready) begin
        check("mem_expected", 64'(mem_q.size() > 0), 1);
        if (mem_q.size() > 0) begin
          e = mem_q.pop_front();
          check("mem_rdata", mem_rdata, e);
        end
      end
      if (if_ready) begin
        check("if_expected", 64'(if_q.size() > 0), 1);
        if (if_q.size() > 0) begin
          e = if_q.pop_front();
          check("if_rdata", if_rdata, e);
        end
      end
    end
  end

  task automatic access(input bit port_if, input bit we,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] wd,
                        input bit withdraw);
    int n, lat, en_n, en_at;
    bit got, held, rdy;
    logic [AW-1:0] en_addr;
    logic [DW-1:0] en_wd;
    logic en_we;
    @(posedge clk); #1;
    if (port_if) begin
      if_q.push_back(ref_mem[a[5:2]]);
      if_req = 1'b1; if_addr = a;
    end else begin
      if (we) ref_mem[a[5:2]] = wd;
      else last_load = ref_mem[a[5:2]];
      mem_q.push_back(last_load);
      mem_req = 1'b1; mem_we = we;
      mem_addr = a; mem_wdata = wd;
    end
    n = 0; lat = -1; got = 0; held = 1;
    en_n = 0; en_at = -1;
    en_addr = '0; en_wd = '0; en_we = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      rdy = port_if ? if_ready : mem_ready;
      if (ram_en) begin
        en_n++; en_at = n;
        en_addr = ram_addr; en_we = ram_we;
        en_wd = ram_wdata;
      end
      check("stall", stall, held && !rdy);
      if (rdy) begin got = 1; lat = n; end
      if (withdraw && n == 1) begin
        mem_req = 1'b0; held = 0;
      end
      n++;
    end
    check("ready_seen", got, 1);
    check("latency", lat, LAT + 2);
    check("ram_en_count", en_n, 1);
    check("ram_en_at", en_at, 1);
    check("ram_addr", en_addr, a);
    check("ram_we", en_we, we);
    if (we) check("ram_wdata", en_wd, wd);
    @(posedge clk); #1;
    mem_req = 1'b0; if_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("idle_en", ram_en, 0);
      check("idle_stall", stall, 0);
    end
  endtask

  task automatic contend(input int count);
    int n, k;
    int who [8];
    int at [8];
    @(posedge clk); #1;
    for (int i = 0; i < count; i++) begin
      if (i % 2 == 0) begin
        last_load = ref_mem[3];
        mem_q.push_back(ref_mem[3]);
      end else begin
        if_q.push_back(ref_mem[4]);
      end
    end
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'hC;
    if_req = 1'b1; if_addr = 32'h10;
    n = 0; k = 0;
    while (k < count && n < 100) begin
      @(negedge clk);
      check("dual_ready", mem_ready & if_ready, 0);
      if (mem_ready || if_ready) begin
        who[k] = int'(if_ready); at[k] = n; k++;
      end
      n++;
    end
    @(posedge clk); #1;
    mem_req = 1'b0; if_req = 1'b0;
    check("grants", k, count);
    for (int i = 0; i < k; i++) begin
      check("grant_order", who[i], i % 2);
      if (i == 0) check("first_ready", at[0], LAT + 2);
      else check("ready_gap", at[i] - at[i-1], LAT + 3);
    end
    @(negedge clk);
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_ram_en"}, ram_en, 0);
    check({tag, "_ram_we"}, ram_we, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_ram_wdata"}, ram_wdata, 0);
    check({tag, "_mem_ready"}, mem_ready, 0);
    check({tag, "_if_ready"}, if_ready, 0);
    check({tag, "_mem_rdata"}, mem_rdata, 0);
    check({tag, "_if_rdata"}, if_rdata, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    outputs_zero("reset");
    check("reset_stall", stall, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    contend(4);
    access(0, 0, 32'h4, '0, 0);
    access(0, 1, 32'h8, 32'hDEAD_BEEF, 0);
    access(0, 0, 32'h8, '0, 0);
    access(1, 0, 32'h14, '0, 0);
    access(0, 0, 32'h18, '0, 1);

    // Reset during WAIT: lost access never completes
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h1C;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    mem_req = 1'b0;
    #1;
    outputs_zero("midrst");
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_ready", mem_ready | if_ready, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_load = '0;

    contend(2);
    access(0, 0, 32'h1C, '0, 0);

    check("mem_q_empty", mem_q.size(), 0);
    check("if_q_empty", if_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
